// File: rtl/fifo_8to16_pkg.sv
// Shared widths, depth default and helpers for the byte/word FIFO family
// (fifo_8to16 and fifo16to8).
package fifo_8to16_pkg;

    localparam int BYTE_W        = 8;
    localparam int WORD_W        = 16;
    localparam int DEFAULT_DEPTH = 16;

    // Byte-pairing register state: nothing held, or a lone low byte held.
    typedef enum logic {
        PK_IDLE = 1'b0,
        PK_HELD = 1'b1
    } pack_state_t;

    // First byte of a pair lands in the low half, second in the high half.
    function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] hi,
                                                    input logic [BYTE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/fifo_8to16_if.sv
// Byte-in / word-out handshake bundle of fifo_8to16.
interface fifo_8to16_if
    import fifo_8to16_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              write_en;
    logic [BYTE_W-1:0] data_in;
    logic              flush;
    logic              read_en;
    logic [WORD_W-1:0] data_out;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              partial;
    logic [CNT_W-1:0]  word_count;

    // Producer/consumer side driving the FIFO.
    modport master (
        output write_en, data_in, flush, read_en,
        input  data_out, rd_valid, empty, full, partial, word_count
    );

    // The FIFO itself.
    modport slave (
        input  write_en, data_in, flush, read_en,
        output data_out, rd_valid, empty, full, partial, word_count
    );

endinterface

// File: rtl/fifo_8to16_pack.sv
// Byte-pairing holding register: collects a low byte, then emits a 16-bit
// word plus a one-cycle commit strobe on the second byte or on a flush.
module fifo_8to16_pack
    import fifo_8to16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              flush_i,
    input  logic              full_i,
    output logic [WORD_W-1:0] word_o,
    output logic              commit_o,
    output logic              partial_o
);

    pack_state_t       state_q, state_d;
    logic [BYTE_W-1:0] held_q, held_d;
    logic              wr_acc;
    logic              fl_acc;

    // A write while full is dropped; a flush only acts on a held byte and
    // loses to a write in the same cycle.
    assign wr_acc = write_en_i & ~full_i;
    assign fl_acc = flush_i & ~write_en_i & ~full_i & (state_q == PK_HELD);

    // Next-state, held byte and commit decode.
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        commit_o = 1'b0;
        word_o   = pack_word(data_i, held_q);
        case (state_q)
            PK_IDLE: begin
                if (wr_acc) begin
                    held_d  = data_i;
                    state_d = PK_HELD;
                end
            end
            PK_HELD: begin
                if (wr_acc) begin
                    commit_o = 1'b1;
                    state_d  = PK_IDLE;
                end else if (fl_acc) begin
                    commit_o = 1'b1;
                    word_o   = pack_word('0, held_q);
                    state_d  = PK_IDLE;
                end
            end
            default: state_d = PK_IDLE;
        endcase
    end

    // State and held byte registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PK_IDLE;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    assign partial_o = (state_q == PK_HELD);

endmodule

// File: rtl/fifo_8to16.sv
// Byte-to-word FIFO: pairs incoming bytes into 16-bit words (first byte low),
// stores DEPTH committed words and returns them through a registered port.
// DEPTH must be a power of two (>= 2) so the pointers wrap on their own.
module fifo_8to16
    import fifo_8to16_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    fifo_8to16_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              vld_q, vld_d;

    logic              full;
    logic              empty;
    logic              rd_acc;
    logic              commit;
    logic [WORD_W-1:0] commit_word;
    logic              partial;

    // Gating always looks at the count before the edge, so a same-cycle
    // read cannot make room for a write and a same-cycle commit cannot
    // satisfy a read.
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign rd_acc = bus.read_en & ~empty;

    fifo_8to16_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .write_en_i (bus.write_en),
        .data_i     (bus.data_in),
        .flush_i    (bus.flush),
        .full_i     (full),
        .word_o     (commit_word),
        .commit_o   (commit),
        .partial_o  (partial)
    );

    // Word storage; contents survive reset, only pointers are cleared.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr_q] <= commit_word;
        end
    end

    // Pointer, occupancy and read-port next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        vld_d    = rd_acc;
        if (commit) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            dout_d   = mem[rd_ptr_q];
        end
        case ({commit, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and read-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.rd_valid   = vld_q;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.partial    = partial;
    assign bus.word_count = count_q;

endmodule

// File: tb/tb_fifo_8to16.sv
// Testbench for fifo_8to16: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_fifo_8to16;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fifo_8to16_if #(.DEPTH(DEPTH)) bus ();

    fifo_8to16 #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of committed words plus the pending byte.
    logic [15:0] m_q[$];
    logic        m_partial = 1'b0;
    logic [7:0]  m_held    = 8'h00;
    logic [15:0] m_dout    = 16'h0000;
    logic        m_vld     = 1'b0;

    typedef struct {
        logic        we;
        logic [7:0]  din;
        logic        fl;
        logic        re;
        logic [15:0] dout;
        logic        vld;
        int          cnt;
        logic        part;
        logic        emp;
        logic        ful;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_partial = 1'b0;
        m_held    = 8'h00;
        m_dout    = 16'h0000;
        m_vld     = 1'b0;
    endtask

    // One clock edge of the FIFO's behaviour, judged on pre-edge occupancy.
    task automatic model_step(input logic we, input logic [7:0] d, input logic fl, input logic re);
        bit was_full;
        bit was_empty;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        m_vld = 1'b0;
        if (re && !was_empty) begin
            m_dout = m_q.pop_front();
            m_vld  = 1'b1;
        end
        if (we && !was_full) begin
            if (m_partial) begin
                m_q.push_back({d, m_held});
                m_partial = 1'b0;
            end else begin
                m_held    = d;
                m_partial = 1'b1;
            end
        end else if (fl && !we && m_partial && !was_full) begin
            m_q.push_back({8'h00, m_held});
            m_partial = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".data_out"},   32'(bus.data_out),   32'(m_dout));
        chk({tag, ".rd_valid"},   32'(bus.rd_valid),   32'(m_vld));
        chk({tag, ".word_count"}, 32'(bus.word_count), 32'(m_q.size()));
        chk({tag, ".partial"},    32'(bus.partial),    32'(m_partial));
        chk({tag, ".empty"},      32'(bus.empty),      32'(m_q.size() == 0));
        chk({tag, ".full"},       32'(bus.full),       32'(m_q.size() == DEPTH));
    endtask

    task automatic idle_inputs();
        bus.write_en = 1'b0;
        bus.data_in  = 8'h00;
        bus.flush    = 1'b0;
        bus.read_en  = 1'b0;
    endtask

    // Drive one cycle, advance the model at the edge, sample 1 ns later.
    task automatic cycle(input string tag, input logic we, input logic [7:0] d,
                         input logic fl, input logic re);
        bus.write_en = we;
        bus.data_in  = d;
        bus.flush    = fl;
        bus.read_en  = re;
        @(posedge clk);
        model_step(we, d, fl, re);
        #1;
        check_model(tag);
        idle_inputs();
    endtask

    // Reset asserted between edges; outputs must clear before any clock.
    task automatic do_reset(input string tag);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".async_data_out"}, 32'(bus.data_out),   32'h0);
        chk({tag, ".async_empty"},    32'(bus.empty),      32'h1);
        chk({tag, ".async_partial"},  32'(bus.partial),    32'h0);
        check_model(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 5);
    endfunction

    initial begin
        idle_inputs();

        do_reset("reset");

        // Directed vectors from power-up: pairing order, flush, flush
        // losing to write, read-while-empty with a same-cycle commit,
        // and simultaneous commit + read.
        vt[0]  = '{1'b1, 8'h34, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 1'b1, 0, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h1234, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 8'hAB, 1'b0, 1'b0, 16'h1234, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h1234, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h00AB, 1'b1, 0, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h00AB, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 8'h55, 1'b0, 1'b0, 16'h00AB, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        vt[10] = '{1'b1, 8'h66, 1'b1, 1'b0, 16'h00AB, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b1, 8'h77, 1'b0, 1'b1, 16'h6655, 1'b1, 0, 1'b1, 1'b1, 1'b0};
        vt[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 16'h6655, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h0077, 1'b1, 0, 1'b0, 1'b1, 1'b0};
        vt[14] = '{1'b1, 8'h01, 1'b0, 1'b0, 16'h0077, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        vt[15] = '{1'b1, 8'h02, 1'b0, 1'b0, 16'h0077, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vt[16] = '{1'b1, 8'h03, 1'b0, 1'b0, 16'h0077, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vt[17] = '{1'b1, 8'h04, 1'b0, 1'b1, 16'h0201, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        vt[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h0403, 1'b1, 0, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 19; i++) begin
            cycle($sformatf("vec%0d", i), vt[i].we, vt[i].din, vt[i].fl, vt[i].re);
            chk($sformatf("vec%0d.data_out", i),   32'(bus.data_out),   32'(vt[i].dout));
            chk($sformatf("vec%0d.rd_valid", i),   32'(bus.rd_valid),   32'(vt[i].vld));
            chk($sformatf("vec%0d.word_count", i), 32'(bus.word_count), 32'(vt[i].cnt));
            chk($sformatf("vec%0d.partial", i),    32'(bus.partial),    32'(vt[i].part));
            chk($sformatf("vec%0d.empty", i),      32'(bus.empty),      32'(vt[i].emp));
            chk($sformatf("vec%0d.full", i),       32'(bus.full),       32'(vt[i].ful));
        end

        // Fill to full, drop one extra byte, drain in order.
        do_reset("fill_reset");
        for (int i = 0; i < 2 * DEPTH; i++) begin
            cycle("fill", 1'b1, pat(i), 1'b0, 1'b0);
        end
        chk("fill.full", 32'(bus.full), 32'h1);
        chk("fill.word_count", 32'(bus.word_count), 32'(DEPTH));
        cycle("drop", 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("drop.word_count", 32'(bus.word_count), 32'(DEPTH));
        chk("drop.partial", 32'(bus.partial), 32'h0);
        for (int k = 0; k < DEPTH; k++) begin
            cycle("drain", 1'b0, 8'h00, 1'b0, 1'b1);
            chk($sformatf("drain%0d.data_out", k), 32'(bus.data_out),
                32'({pat(2 * k + 1), pat(2 * k)}));
            chk($sformatf("drain%0d.rd_valid", k), 32'(bus.rd_valid), 32'h1);
        end
        chk("drain.empty", 32'(bus.empty), 32'h1);

        // Write and read together while full: the read wins the slot, the
        // write is dropped. Every commit consumes the pending byte, so full
        // is only ever reached with nothing pending.
        for (int i = 0; i < 2 * DEPTH; i++) begin
            cycle("refill", 1'b1, pat(i + 100), 1'b0, 1'b0);
        end
        cycle("full_rw", 1'b1, 8'h99, 1'b0, 1'b1);
        chk("full_rw.rd_valid", 32'(bus.rd_valid), 32'h1);
        chk("full_rw.data_out", 32'(bus.data_out), 32'({pat(101), pat(100)}));
        chk("full_rw.word_count", 32'(bus.word_count), 32'(DEPTH - 1));
        chk("full_rw.partial", 32'(bus.partial), 32'h0);

        // Read while empty holds data_out; reset mid-stream clears all.
        do_reset("rd_empty_reset");
        cycle("pre", 1'b1, 8'h11, 1'b0, 1'b0);
        cycle("pre", 1'b1, 8'h22, 1'b0, 1'b0);
        cycle("pre", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("pre.data_out", 32'(bus.data_out), 32'h2211);
        cycle("rd_empty", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("rd_empty.data_out", 32'(bus.data_out), 32'h2211);
        chk("rd_empty.rd_valid", 32'(bus.rd_valid), 32'h0);
        cycle("mid", 1'b1, 8'hA1, 1'b0, 1'b0);
        cycle("mid", 1'b1, 8'hA2, 1'b0, 1'b0);
        cycle("mid", 1'b1, 8'hA3, 1'b0, 1'b0);
        do_reset("mid_reset");
        cycle("post", 1'b1, 8'h34, 1'b0, 1'b0);
        cycle("post", 1'b1, 8'h12, 1'b0, 1'b0);
        cycle("post", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("post.data_out", 32'(bus.data_out), 32'h1234);
        chk("post.empty", 32'(bus.empty), 32'h1);

        // Random interleaving over many pointer wraps.
        for (int n = 0; n < 1200; n++) begin
            logic we, fl, re;
            logic [7:0] d;
            we = ($urandom_range(99) < 50);
            fl = ($urandom_range(99) < 12);
            re = ($urandom_range(99) < 40);
            d  = 8'($urandom);
            cycle("rand", we, d, fl, re);
        end
        for (int n = 0; n < DEPTH + 1; n++) begin
            cycle("rand_drain", 1'b0, 8'h00, 1'b0, 1'b1);
        end
        chk("rand_drain.empty", 32'(bus.empty), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
